// File: rtl/painterengine_gpu_dma_read_scheduler.sv
// painterengine_gpu_dma_read_scheduler: 4-channel DMA reader job scheduler (IDLE/ARM/RUN/RELEASE) with watchdog.
// Define PAINTERENGINE_GPU_SCHED_FIXED_PRIORITY_EN for fixed-priority grant instead of round-robin.
module painterengine_gpu_dma_read_scheduler #(
    parameter logic [19:0] WATCHDOG_LIMIT = 20'hFFFFF,
    parameter int          RELEASE_CYCLES = 2
) (
    input  logic         i_wire_clock,
    input  logic         i_wire_reset,
    input  logic [3:0]   i_wire_req,
    input  logic [127:0] i_wire_address,
    input  logic [127:0] i_wire_length,
    output logic [3:0]   o_wire_ack,
    output logic [3:0]   o_wire_ack_error,
    output logic         o_wire_busy,
    output logic         o_wire_reader_resetn,
    output logic [127:0] o_wire_reader_address,
    output logic [127:0] o_wire_reader_length,
    output logic [3:0]   o_wire_reader_router,
    input  logic         i_wire_reader_done,
    input  logic         i_wire_reader_error
);
    typedef enum logic [1:0] {IDLE, ARM, RUN, RELEASE} state_t;
    state_t state, state_d;
    logic [19:0] wd, wd_d;
    logic [3:0] rel, rel_d;
    logic [1:0] base, ch, grant;
    logic found, timeout;
    logic [3:0] ack_d, err_d, router_d;
    logic resetn_d;
    logic [127:0] addr_d, len_d;
`ifdef PAINTERENGINE_GPU_SCHED_FIXED_PRIORITY_EN
    always_comb base = 2'd0;
`else
    logic [1:0] ptr, ptr_d;
    always_comb base = ptr + 2'd1;
`endif
    // Scan downward so the channel closest to base wins.
    always_comb begin
        grant = 2'd0;
        found = 1'b0;
        ch = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            ch = base + 2'(i);
            if (i_wire_req[ch]) begin
                grant = ch;
                found = 1'b1;
            end
        end
    end
    assign timeout = (wd + 20'd1) == WATCHDOG_LIMIT;
    always_comb begin
        state_d = state;
        wd_d = wd;
        rel_d = rel;
        ack_d = 4'd0;
        err_d = 4'd0;
        resetn_d = 1'b0;
        router_d = o_wire_reader_router;
        addr_d = o_wire_reader_address;
        len_d = o_wire_reader_length;
`ifndef PAINTERENGINE_GPU_SCHED_FIXED_PRIORITY_EN
        ptr_d = ptr;
`endif
        case (state)
            IDLE: begin
                router_d = 4'd0;
                addr_d = '0;
                len_d = '0;
                if (found) begin
                    state_d = ARM;
                    router_d = 4'b0001 << grant;
                    for (int n = 0; n < 4; n++) begin
                        addr_d[n*32+:32] = (2'(n) == grant) ? i_wire_address[n*32+:32] : 32'd0;
                        len_d[n*32+:32] = (2'(n) == grant) ? i_wire_length[n*32+:32] : 32'd0;
                    end
`ifndef PAINTERENGINE_GPU_SCHED_FIXED_PRIORITY_EN
                    ptr_d = grant;
`endif
                end
            end
            ARM: begin
                state_d = RUN;
                resetn_d = 1'b1;
                wd_d = 20'd0;
            end
            RUN: begin
                wd_d = wd + 20'd1;
                resetn_d = 1'b1;
                if (i_wire_reader_done || i_wire_reader_error || timeout) begin
                    state_d = RELEASE;
                    ack_d = o_wire_reader_router;
                    err_d = (i_wire_reader_error || timeout) ? o_wire_reader_router : 4'd0;
                    resetn_d = 1'b0;
                    router_d = 4'd0;
                    addr_d = '0;
                    len_d = '0;
                    rel_d = 4'd0;
                end
            end
            default: begin
                rel_d = rel + 4'd1;
                state_d = (rel == 4'(RELEASE_CYCLES - 1)) ? IDLE : RELEASE;
            end
        endcase
    end
    always_ff @(posedge i_wire_clock or posedge i_wire_reset) begin
        if (i_wire_reset) begin
            state <= IDLE;
            wd <= 20'd0;
            rel <= 4'd0;
            o_wire_ack <= 4'd0;
            o_wire_ack_error <= 4'd0;
            o_wire_busy <= 1'b0;
            o_wire_reader_resetn <= 1'b0;
            o_wire_reader_router <= 4'd0;
            o_wire_reader_address <= '0;
            o_wire_reader_length <= '0;
`ifndef PAINTERENGINE_GPU_SCHED_FIXED_PRIORITY_EN
            ptr <= 2'd3;
`endif
        end else begin
            state <= state_d;
            wd <= wd_d;
            rel <= rel_d;
            o_wire_ack <= ack_d;
            o_wire_ack_error <= err_d;
            o_wire_busy <= state_d != IDLE;
            o_wire_reader_resetn <= resetn_d;
            o_wire_reader_router <= router_d;
            o_wire_reader_address <= addr_d;
            o_wire_reader_length <= len_d;
`ifndef PAINTERENGINE_GPU_SCHED_FIXED_PRIORITY_EN
            ptr <= ptr_d;
`endif
        end
    end
endmodule

// File: tb/tb_painterengine_gpu_dma_read_scheduler.sv
// tb_painterengine_gpu_dma_read_scheduler: directed jobs with an ack/ack_error scoreboard and a separate monitor.
module tb_painterengine_gpu_dma_read_scheduler;
    logic clk = 0, rst = 1, done = 0, err = 0;
    logic [3:0] req = 0;
    logic [127:0] addr, len;
    logic [3:0] ack, ack_err, router;
    logic busy, resetn;
    logic [127:0] raddr, rlen;
    int total = 0, bad = 0;
    logic [7:0] sb[$];
    logic [7:0] e;
    always #5 clk = ~clk;
    painterengine_gpu_dma_read_scheduler #(.WATCHDOG_LIMIT(20'd100), .RELEASE_CYCLES(2)) dut (
        .i_wire_clock(clk), .i_wire_reset(rst), .i_wire_req(req),
        .i_wire_address(addr), .i_wire_length(len),
        .o_wire_ack(ack), .o_wire_ack_error(ack_err), .o_wire_busy(busy),
        .o_wire_reader_resetn(resetn), .o_wire_reader_address(raddr),
        .o_wire_reader_length(rlen), .o_wire_reader_router(router),
        .i_wire_reader_done(done), .i_wire_reader_error(err)
    );
    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask
    always @(negedge clk) begin
        if (ack !== 4'd0 || ack_err !== 4'd0) begin
            if (sb.size() == 0) chk("unexpected_ack", {ack, ack_err}, 8'd0);
            else begin
                e = sb.pop_front();
                chk("ack", {ack, ack_err}, e);
            end
        end
    end
    // mode: 0 done, 1 error, 2 done+error, 3 silent (watchdog)
    task automatic job(input int ch, input int mode, input int run_n, input int exp_run, input bit early);
        int n;
        logic [3:0] oh;
        oh = 4'b0001 << ch;
        sb.push_back({oh, (mode != 0) ? oh : 4'd0});
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (router == 4'd0 && n < 20);
        chk("arm_router", router, oh);
        chk("arm_addr", raddr, 128'(addr[ch*32+:32]) << (ch*32));
        chk("arm_len", rlen, 128'(len[ch*32+:32]) << (ch*32));
        chk("arm_resetn", resetn, 0);
        if (early) req[ch] = 0;
        @(negedge clk);
        n = 0;
        while (resetn === 1'b1 && n < 300) begin
            n++;
            if (n == run_n) begin
                done = (mode == 0 || mode == 2);
                err = (mode == 1 || mode == 2);
            end
            @(negedge clk);
        end
        chk("run_cycles", n, exp_run);
        chk("rel_router", router, 0);
        chk("rel_addr", raddr, 0);
        done = 0;
        err = 0;
        req[ch] = 0;
    endtask
    initial begin
        for (int n = 0; n < 4; n++) begin
            addr[n*32+:32] = 32'h1000 + 32'(n) * 32'h100;
            len[n*32+:32] = 32'd64 + 32'(n);
        end
        repeat (2) @(negedge clk);
        chk("rst_outs", {ack, ack_err, busy, resetn, router, raddr, rlen}, 0);
        rst = 0;
        @(negedge clk);
        chk("idle_busy", busy, 0);
        req = 4'b0001;
        job(0, 0, 70, 70, 0);
        @(negedge clk);
        chk("rel2_busy", busy, 1);
        @(negedge clk);
        chk("idle_after_rel", busy, 0);
        req = 4'b0010;
        job(1, 1, 5, 5, 1);
        req = 4'b0101;
`ifdef PAINTERENGINE_GPU_SCHED_FIXED_PRIORITY_EN
        job(0, 0, 3, 3, 0);
        job(2, 0, 3, 3, 0);
`else
        job(2, 0, 3, 3, 0);
        job(0, 0, 3, 3, 0);
`endif
        req = 4'b1000;
        job(3, 2, 4, 4, 0);
        req = 4'b0001;
        job(0, 3, 0, 100, 0);
        req = 4'b0100;
        begin
            int n;
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (router == 4'd0 && n < 20);
            chk("rst_job_router", router, 4'b0100);
            repeat (3) @(negedge clk);
            chk("rst_job_running", resetn, 1);
            rst = 1;
            #1;
            chk("midjob_rst_outs", {ack, ack_err, busy, resetn, router, raddr, rlen}, 0);
            req = 0;
            @(negedge clk);
            rst = 0;
        end
        req = 4'b0100;
        job(2, 0, 6, 6, 0);
        @(negedge clk);
        rst = 1;
        @(negedge clk);
        rst = 0;
        req = 4'b1111;
        for (int c = 0; c < 4; c++) job(c, 0, 2, 2, 0);
        repeat (5) @(negedge clk);
        chk("sb_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
    initial begin
        #200000;
        $display("FAIL timeout: got running want finished");
        $fatal(1);
    end
endmodule
